reg_share_arbiter: RTL and testbench
====================================

# reg_share_arbiter

Round-robin arbiter that shares a single registered D-flip-flop bank (q/qn pair) among NREQ requesters. A granted requester loads its data word into the shared register every cycle it holds ownership. Ownership is bounded by a hold limit, and requesters rotate fairly. The block sits in front of the shared dff storage and is its only writer.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, data/register width
- MAX_HOLD, 4, maximum consecutive owned cycles per grant (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- d  in  NREQ*WIDTH  packed data; requester i at d[i*WIDTH +: WIDTH]
- gnt  out  NREQ  registered one-hot grant (all-zero when idle)
- owner  out  $clog2(NREQ)  index of current owner; valid when busy=1
- busy  out  1  high while a grant is active
- q  out  WIDTH  shared register value
- qn  out  WIDTH  always ~q

## Operation
- States: IDLE and OWN. Internal: rr_ptr (round-robin start index) and hold_cnt (1..MAX_HOLD).
- Winner selection: first i with req[i]=1, scanning rr_ptr, rr_ptr+1, …, wrapping modulo NREQ.
- IDLE: if any req is high, the next edge moves to OWN. At that edge: gnt=onehot(winner), owner=winner, q<=d[winner], hold_cnt<=1, busy=1. If no req is high, remain in IDLE and q holds its value.
- OWN, continue: if req[owner]=1 and hold_cnt<MAX_HOLD, then q<=d[owner] and hold_cnt++.
- OWN, end of grant: occurs when req[owner]=0 or hold_cnt==MAX_HOLD.
  - rr_ptr<=(owner+1) mod NREQ.
  - The winner is picked with the scan starting at owner+1, so the current owner ranks last.
  - If a winner exists, grant it on the same edge with no idle cycle between owners: load q<=d[new], hold_cnt<=1.
  - If no winner exists, go to IDLE: gnt=0, busy=0, q holds, owner holds its last value.
- A sole requester whose hold expires is re-granted immediately. gnt stays set and hold_cnt restarts at 1.
- MAX_HOLD=1: each grant lasts exactly one cycle. Under full contention the grant rotates every cycle.
- q is written only from the granted requester's d, and never while in IDLE.
- Reset (reset=0, async): state=IDLE, gnt=0, owner=0, busy=0, q=0, qn=all-ones, rr_ptr=0, hold_cnt=0. Asserting reset in mid-grant aborts the grant immediately, without waiting for a clock edge.

## Timing
- Latency from a sampled req to the gnt/q update is one clock edge. Outputs change only on rising clk or on reset assertion.
- q reflects d[owner] as sampled at the same edge that asserted or kept the grant.
- Requesters must hold req high to keep ownership. A req drop is seen at the next edge, and the grant ends there.
- Full contention with MAX_HOLD=M: each requester owns the register for exactly M consecutive cycles, in order rr_ptr, rr_ptr+1, ….
- A req asserted at the same edge a grant ends competes normally in that edge's selection.
- Reset deassertion is synchronized by the integrator. The first possible grant is at the first clk edge after reset goes high.

## Structure
- Package reg_share_pkg contains:
  - state enum {IDLE, OWN}
  - localparam IDX_W = $clog2(NREQ)
  - the next-index wrap function
- Sub-module rr_pick: a combinational round-robin picker. Inputs: req and start index. Outputs: found and index.
- Top module: FSM, hold counter, rr_ptr, and the shared q register with qn = ~q.

## Test plan
- Reset: drive reset=0 with random req/d. Required: gnt=0, busy=0, q=8'h00, qn=8'hFF. After reset=1 with all req=0, the block stays idle.
- Single requester: req=4'b0100, d[2] = 8'hA1, 8'hA2, 8'hA3 on successive cycles. Required: gnt=4'b0100, owner=2, and q follows A1, A2, A3 one edge later. Dropping req ends the grant (busy=0), and q holds 8'hA3.
- Full contention with MAX_HOLD=4 and req=4'b1111 from reset. Required grant sequence: owner 0×4, 1×4, 2×4, 3×4, 0×4. There is no idle cycle between owners, and q always equals the owner's d.
- Hold expiry for a sole requester: req=4'b0010 held for 10 cycles with MAX_HOLD=4. Required: gnt stays 4'b0010 continuously and hold_cnt cycles 1..4.
- Handover on release: owner 1 drops req while req[3] is high. Required: the next edge gives gnt=4'b1000, owner=3, q=d[3]. rr_ptr becomes 2, so requester 3 wins over requester 0 if both are requesting.
- Reset mid-grant: assert reset=0 between edges while owner=2. Required: gnt/q/busy clear immediately, without a clock edge. After release, the first grant scans from rr_ptr=0.

Source files
------------

// File: rtl/reg_share_pkg.sv
//------------------------------------------------------------------------------
// reg_share_pkg : shared types, widths and index helper for reg_share_arbiter
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package reg_share_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam int NREQ_DFLT = 4;
  localparam int IDX_W     = $clog2(NREQ_DFLT);

  // Index after idx, wrapping back to 0 at n.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, first request at or after start
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic            found,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(start) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_share_arbiter.sv
//------------------------------------------------------------------------------
// reg_share_arbiter : round-robin owner of a shared q/qn register bank
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     d,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic [WIDTH-1:0]          q,
  output logic [WIDTH-1:0]          qn
);

  localparam int OW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_e            state_q,    state_d;
  logic [NREQ-1:0]   gnt_q,      gnt_d;
  logic [OW-1:0]     owner_q,    owner_d;
  logic [WIDTH-1:0]  q_q,        q_d;
  logic [OW-1:0]     rr_ptr_q,   rr_ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;

  logic              grant_end;
  logic [OW-1:0]     pick_start;
  logic              pick_found;
  logic [OW-1:0]     pick_idx;

  assign grant_end  = !req[owner_q] || (hold_cnt_q == HW'(MAX_HOLD));
  // When a grant ends the current owner must rank last, so scan from owner+1.
  assign pick_start = (state_q == OWN) ? OW'(next_idx(int'(owner_q), NREQ)) : rr_ptr_q;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (OW)
  ) u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      q_q        <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      q_q        <= q_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    q_d        = q_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = OWN;
          gnt_d      = NREQ'(1) << pick_idx;
          owner_d    = pick_idx;
          q_d        = d[pick_idx*WIDTH +: WIDTH];
          hold_cnt_d = HW'(1);
        end
      end
      OWN: begin
        if (!grant_end) begin
          q_d        = d[owner_q*WIDTH +: WIDTH];
          hold_cnt_d = hold_cnt_q + HW'(1);
        end else begin
          rr_ptr_d = pick_start;
          if (pick_found) begin
            gnt_d      = NREQ'(1) << pick_idx;
            owner_d    = pick_idx;
            q_d        = d[pick_idx*WIDTH +: WIDTH];
            hold_cnt_d = HW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    gnt   = gnt_q;
    owner = owner_q;
    busy  = (state_q == OWN);
    q     = q_q;
    qn    = ~q_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
//------------------------------------------------------------------------------
// tb_reg_share_arbiter : self-checking bench for reg_share_arbiter
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] d     = '0;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   q;
  logic [W-1:0]   qn;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit           m_busy;
  int           m_owner;
  int           m_hold;
  int           m_ptr;
  logic [W-1:0] m_q;

  reg_share_arbiter #(.NREQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .d     (d),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q),
    .qn    (qn)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int start);
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] dw(input int i);
    return d[i*W +: W];
  endfunction

  function automatic logic [N-1:0] m_gnt();
    return m_busy ? (N'(1) << m_owner) : '0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_hold = 0; m_ptr = 0; m_q = '0;
  endtask

  task automatic model_edge();
    int w;
    if (!m_busy) begin
      w = pick(m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_q = dw(w); m_hold = 1;
      end
    end else if (req[m_owner] && m_hold < MH) begin
      m_q = dw(m_owner); m_hold++;
    end else begin
      m_ptr = (m_owner + 1) % N;
      w = pick(m_ptr);
      if (w >= 0) begin
        m_owner = w; m_q = dw(w); m_hold = 1;
      end else begin
        m_busy = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req = N'($urandom); d = $urandom;
    #3;
    n_checks++; if (gnt !== '0)     begin n_fail++; $display("FAIL reset_gnt got %b want 0", gnt); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (q !== 8'h00)    begin n_fail++; $display("FAIL reset_q got %h want 00", q); end
    n_checks++; if (qn !== 8'hFF)   begin n_fail++; $display("FAIL reset_qn got %h want ff", qn); end
    step();
    n_checks++; if (gnt !== '0)     begin n_fail++; $display("FAIL reset_held_gnt got %b want 0", gnt); end
    model_reset();
    req = '0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (busy !== 1'b0 || gnt !== '0)
        begin n_fail++; $display("FAIL idle_after_reset busy=%b gnt=%b want 0/0", busy, gnt); end
    end
  endtask

  task automatic test_single();
    logic [W-1:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3;
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      d[2*W +: W] = vals[i];
      step();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got %b want 0100", gnt); end
      n_checks++; if (owner !== 2'd2)  begin n_fail++; $display("FAIL single_owner got %0d want 2", owner); end
      n_checks++; if (q !== vals[i])   begin n_fail++; $display("FAIL single_q got %h want %h", q, vals[i]); end
    end
    req = '0; d = $urandom;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_release_busy got %b want 0", busy); end
    n_checks++; if (q !== 8'hA3)   begin n_fail++; $display("FAIL single_release_q got %h want a3", q); end
    n_checks++; if (qn !== 8'h5C)  begin n_fail++; $display("FAIL single_release_qn got %h want 5c", qn); end
  endtask

  task automatic test_contention();
    int eo;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      d = $urandom;
      step();
      eo = (c / MH) % N;
      n_checks++; if (owner !== 2'(eo) || gnt !== (N'(1) << eo) || busy !== 1'b1)
        begin n_fail++; $display("FAIL contention_owner c=%0d got owner=%0d gnt=%b busy=%b want owner=%0d", c, owner, gnt, busy, eo); end
      n_checks++; if (q !== dw(eo))
        begin n_fail++; $display("FAIL contention_q c=%0d got %h want %h", c, q, dw(eo)); end
    end
  endtask

  task automatic test_sole_expiry();
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      d = $urandom;
      step();
      n_checks++; if (gnt !== 4'b0010)
        begin n_fail++; $display("FAIL sole_gnt c=%0d got %b want 0010", c, gnt); end
      n_checks++; if (int'(dut.hold_cnt_q) !== (c % MH) + 1)
        begin n_fail++; $display("FAIL sole_hold c=%0d got %0d want %0d", c, dut.hold_cnt_q, (c % MH) + 1); end
    end
  endtask

  task automatic test_handover();
    do_reset();
    req = 4'b0010; d = $urandom;
    step();
    req = 4'b1011; d = $urandom;
    step();
    n_checks++; if (owner !== 2'd1) begin n_fail++; $display("FAIL handover_pre got owner %0d want 1", owner); end
    req = 4'b1001; d = $urandom;
    step();
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL handover_gnt got %b want 1000", gnt); end
    n_checks++; if (owner !== 2'd3)  begin n_fail++; $display("FAIL handover_owner got %0d want 3", owner); end
    n_checks++; if (q !== dw(3))     begin n_fail++; $display("FAIL handover_q got %h want %h", q, dw(3)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; d = $urandom;
    step();
    step();
    n_checks++; if (owner !== 2'd2 || busy !== 1'b1)
      begin n_fail++; $display("FAIL midreset_pre got owner=%0d busy=%b want 2/1", owner, busy); end
    req = 4'b1111;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (gnt !== '0 || busy !== 1'b0 || q !== '0)
      begin n_fail++; $display("FAIL midreset_async got gnt=%b busy=%b q=%h want 0/0/00", gnt, busy, q); end
    model_reset();
    reset = 1'b1;
    step();
    n_checks++; if (owner !== 2'd0 || gnt !== 4'b0001)
      begin n_fail++; $display("FAIL midreset_first got owner=%0d gnt=%b want 0/0001", owner, gnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) < 35) req = N'($urandom);
      d = $urandom;
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || q !== '0)
          begin n_fail++; $display("FAIL random_reset c=%0d got busy=%b q=%h", c, busy, q); end
        model_reset();
        reset = 1'b1;
      end
      step();
      n_checks++; if (gnt !== m_gnt() || busy !== m_busy)
        begin n_fail++; $display("FAIL random_gnt c=%0d got gnt=%b busy=%b want %b/%b", c, gnt, busy, m_gnt(), m_busy); end
      n_checks++; if (owner !== 2'(m_owner))
        begin n_fail++; $display("FAIL random_owner c=%0d got %0d want %0d", c, owner, m_owner); end
      n_checks++; if (q !== m_q || qn !== ~m_q)
        begin n_fail++; $display("FAIL random_q c=%0d got q=%h qn=%h want %h", c, q, qn, m_q); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_sole_expiry();
    test_handover();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
